// File: rtl/mux_n_stream_pkg.sv
// Shared types for the N-input streaming multiplexer.
// The mode enum is the type of the top-level `mode` port.
package mux_n_stream_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_t;

endpackage

// File: rtl/mux_n_stream_rr_pick.sv
// Combinational rotating-priority picker: the search starts one past ptr and wraps,
// so the channel granted last gets the lowest priority next time.
module rr_pick #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [SEL_W-1:0] idx_s;
  logic             found_s;
  logic [SEL_W-1:0] pick_s;

  // Walk the channels in rotated order and keep the first requester found
  always_comb begin
    idx_s   = '0;
    found_s = 1'b0;
    pick_s  = '0;
    for (int k = 1; k <= N; k++) begin
      idx_s = SEL_W'((int'(ptr) + k) % N);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        pick_s  = pick_s;
      end
    end
    gnt_valid = found_s;
    gnt_idx   = pick_s;
  end

endmodule

// File: rtl/mux_n_stream.sv
// N-input, W-bit stream multiplexer with a single registered output stage.
// Select mode follows `sel`; round-robin mode arbitrates fairly among valid inputs.
module mux_n_stream
  import mux_n_stream_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  mux_mode_t        mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_chan
);

  logic [W-1:0]     out_data_r;
  logic             out_valid_r;
  logic [SEL_W-1:0] out_chan_r;
  logic [SEL_W-1:0] rr_ptr_r;

  logic             load_s;
  logic             rr_valid_s;
  logic [SEL_W-1:0] rr_idx_s;
  logic             grant_valid_s;
  logic [SEL_W-1:0] grant_s;
  logic             xfer_s;
  logic [N-1:0]     in_ready_s;

  rr_pick #(.N(N)) u_rr_pick (
    .req       (in_valid),
    .ptr       (rr_ptr_r),
    .gnt_valid (rr_valid_s),
    .gnt_idx   (rr_idx_s)
  );

  // Grant selection; sel beyond the last channel yields no grant
  always_comb begin
    grant_s       = '0;
    grant_valid_s = 1'b0;
    case (mode)
      MODE_SEL: begin
        grant_s       = sel;
        grant_valid_s = (int'(sel) < N) ? in_valid[sel] : 1'b0;
      end
      MODE_RR: begin
        grant_s       = rr_idx_s;
        grant_valid_s = rr_valid_s;
      end
      default: begin
        grant_s       = '0;
        grant_valid_s = 1'b0;
      end
    endcase
  end

  assign load_s = !out_valid_r || out_ready;
  assign xfer_s = load_s && grant_valid_s;

  // Only the granted channel sees ready, and only when the register can load
  always_comb begin
    in_ready_s = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_s[i] = xfer_s && (int'(grant_s) == i);
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_chan_r  <= '0;
      rr_ptr_r    <= SEL_W'(N - 1);
    end else begin
      if (xfer_s) begin
        out_data_r  <= in_data[int'(grant_s)*W +: W];
        out_chan_r  <= grant_s;
        out_valid_r <= 1'b1;
        if (mode == MODE_RR) begin
          rr_ptr_r <= grant_s;
        end else begin
          rr_ptr_r <= rr_ptr_r;
        end
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_mux_n_stream.sv
// Directed self-checking bench for mux_n_stream: a default N=4 instance plus an
// N=3 instance for the out-of-range select case.
module tb_mux_n_stream;
  import mux_n_stream_pkg::*;

  logic       clk;
  logic       reset;
  mux_mode_t  mode;
  logic [1:0] sel;
  logic [31:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_chan;

  mux_mode_t  mode3;
  logic [1:0] sel3;
  logic [23:0] in_data3;
  logic [2:0] in_valid3;
  logic [2:0] in_ready3;
  logic [7:0] out_data3;
  logic       out_valid3;
  logic       out_ready3;
  logic [1:0] out_chan3;

  int tests;
  int fails;
  logic [7:0] exp_data [4];

  mux_n_stream #(.N(4), .W(8)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
  );

  mux_n_stream #(.N(3), .W(8)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_chan(out_chan3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: valid=%b data=%h chan=%0d, want 0/00/0", out_valid, out_data, out_chan);
    end
    reset = 1'b0;
    mode = MODE_SEL; sel = 2'd0; in_data = {8'h00, 8'h00, 8'h00, 8'hA5};
    in_valid = 4'b0001; out_ready = 1'b0;
    tick();
    in_valid = 4'b0000;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      fails++;
      $display("FAIL reset_preload: valid=%b data=%h, want 1/a5", out_valid, out_data);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
      fails++;
      $display("FAIL reset_async: valid=%b data=%h chan=%0d, want 0/00/0", out_valid, out_data, out_chan);
    end
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if (in_ready !== 4'b0000 || in_ready3 !== 3'b000) begin
      fails++;
      $display("FAIL reset_ready: in_ready=%b in_ready3=%b, want 0000/000", in_ready, in_ready3);
    end
  endtask

  task automatic test_select();
    mode = MODE_SEL; sel = 2'd2; in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0100) begin
      fails++;
      $display("FAIL sel2_ready: got %b want 0100", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h33 || out_chan !== 2'd2) begin
      fails++;
      $display("FAIL sel2_out: valid=%b data=%h chan=%0d, want 1/33/2", out_valid, out_data, out_chan);
    end
    sel = 2'd0;
    #1;
    tests++;
    if (in_ready !== 4'b0001) begin
      fails++;
      $display("FAIL sel0_ready: got %b want 0001", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_chan !== 2'd0) begin
      fails++;
      $display("FAIL sel0_out: valid=%b data=%h chan=%0d, want 1/11/0", out_valid, out_data, out_chan);
    end
    in_valid = 4'b0000;
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h11) begin
      fails++;
      $display("FAIL sel_drain: valid=%b data=%h, want 0/11", out_valid, out_data);
    end
  endtask

  task automatic test_round_robin();
    int e;
    mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      e = k % 4;
      tests++;
      if (in_ready !== (4'b0001 << e)) begin
        fails++;
        $display("FAIL rr_ready[%0d]: got %b want chan %0d", k, in_ready, e);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_chan !== 2'(e) || out_data !== exp_data[e]) begin
        fails++;
        $display("FAIL rr_out[%0d]: valid=%b chan=%0d data=%h, want 1/%0d/%h",
                 k, out_valid, out_chan, out_data, e, exp_data[e]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int seq [5];
    seq[0] = 1; seq[1] = 3; seq[2] = 1; seq[3] = 3; seq[4] = 0;
    in_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) in_valid = 4'b1011;
      #1;
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_chan !== 2'(seq[k]) || out_data !== exp_data[seq[k]]) begin
        fails++;
        $display("FAIL rr_sparse[%0d]: chan=%0d data=%h, want %0d/%h",
                 k, out_chan, out_data, seq[k], exp_data[seq[k]]);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = MODE_SEL; sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    tests++;
    if (out_data !== 8'h22 || out_chan !== 2'd1) begin
      fails++;
      $display("FAIL bp_load: data=%h chan=%0d, want 22/1", out_data, out_chan);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0000) begin
        fails++;
        $display("FAIL bp_ready[%0d]: got %b want 0000", k, in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h22 || out_chan !== 2'd1) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h chan=%0d, want 1/22/1", k, out_valid, out_data, out_chan);
      end
    end
    sel = 2'd3; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b1000) begin
      fails++;
      $display("FAIL bp_release_ready: got %b want 1000", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h44 || out_chan !== 2'd3) begin
      fails++;
      $display("FAIL bp_release_out: valid=%b data=%h chan=%0d, want 1/44/3", out_valid, out_data, out_chan);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_n3_sel_oob();
    mode3 = MODE_SEL; sel3 = 2'd3; in_data3 = {8'h33, 8'h22, 8'h11};
    in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (in_ready3 !== 3'b000) begin
        fails++;
        $display("FAIL n3_oob_ready[%0d]: got %b want 000", k, in_ready3);
      end
      tick();
      tests++;
      if (out_valid3 !== 1'b0) begin
        fails++;
        $display("FAIL n3_oob_valid[%0d]: got %b want 0", k, out_valid3);
      end
    end
    sel3 = 2'd2;
    #1;
    tests++;
    if (in_ready3 !== 3'b100) begin
      fails++;
      $display("FAIL n3_sel2_ready: got %b want 100", in_ready3);
    end
    tick();
    tests++;
    if (out_valid3 !== 1'b1 || out_data3 !== 8'h33 || out_chan3 !== 2'd2) begin
      fails++;
      $display("FAIL n3_sel2_out: valid=%b data=%h chan=%0d, want 1/33/2", out_valid3, out_data3, out_chan3);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
    reset = 1'b1;
    mode = MODE_SEL; sel = 2'd0; in_data = 32'h0; in_valid = 4'b0000; out_ready = 1'b0;
    mode3 = MODE_SEL; sel3 = 2'd0; in_data3 = 24'h0; in_valid3 = 3'b000; out_ready3 = 1'b0;
    tick();
    test_reset();
    test_select();
    test_round_robin();
    test_rr_sparse();
    test_backpressure();
    test_n3_sel_oob();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
